reaction_game_ctrl: RTL and testbench

Game controller for the reaction-time game; produces the 3-bit `state` code consumed by the LED matrix/RGB display driver. It detects start/react button edges and draws a pseudo-random wait delay from an LFSR. It times the player's response in milliseconds and reports success, early-press failure or timeout failure through the state encoding.

---
 rtl/reaction_game_ctrl.sv | 117 +++++++++++
 tb/tb_reaction_game_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: button edge detect, LFSR random wait, ms timing, result reporting.
// Define REACTION_BEST_EN to keep the lowest successful reaction time in best_ms.
module reaction_game_ctrl #(
    parameter int CLK_PER_MS   = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        react,
    output logic [2:0]  state,
    output logic [13:0] react_ms,
    output logic        result_valid,
    output logic [13:0] best_ms
);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_WAIT    = 3'b001,
        S_GO      = 3'b011,
        S_FAIL    = 3'b010,
        S_SUCCESS = 3'b111
    } state_t;

    state_t        cur, nxt;
    logic          start_q, react_q;
    logic          start_rise, react_rise;
    logic [15:0]   lfsr;
    logic [PW-1:0] pre;
    logic          tick;
    logic [13:0]   ms_cnt, delay;
    logic          load_delay, hit;

    assign start_rise = start & ~start_q;
    assign react_rise = react & ~react_q;
    assign tick       = (pre == PW'(CLK_PER_MS - 1));
    assign state      = cur;

    always_ff @(posedge clk) begin
        if (!rst_n) cur <= S_IDLE;
        else        cur <= nxt;
    end

    // Early press beats delay expiry; a press on the timeout edge still counts as success.
    always_comb begin
        nxt        = cur;
        load_delay = 1'b0;
        hit        = 1'b0;
        case (cur)
            S_IDLE, S_FAIL, S_SUCCESS:
                if (start_rise) begin
                    nxt        = S_WAIT;
                    load_delay = 1'b1;
                end
            S_WAIT:
                if (react_rise)                              nxt = S_FAIL;
                else if (tick && ms_cnt == delay - 14'd1)    nxt = S_GO;
            S_GO:
                if (react_rise) begin
                    nxt = S_SUCCESS;
                    hit = 1'b1;
                end else if (tick && ms_cnt == 14'(TIMEOUT_MS - 1)) begin
                    nxt = S_FAIL;
                end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            react_q      <= 1'b0;
            lfsr         <= 16'hACE1;
            pre          <= '0;
            ms_cnt       <= '0;
            delay        <= '0;
            react_ms     <= '0;
            result_valid <= 1'b0;
        end else begin
            start_q      <= start;
            react_q      <= react;
            lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            result_valid <= hit;
            // Timebase restarts on every state entry so WAIT/GO durations are exact.
            if (nxt != cur) begin
                pre    <= '0;
                ms_cnt <= '0;
            end else if (tick) begin
                pre    <= '0;
                ms_cnt <= ms_cnt + 14'd1;
            end else begin
                pre    <= pre + 1'b1;
            end
            if (load_delay) delay <= 14'(MIN_DELAY_MS) + 14'(lfsr[RAND_BITS-1:0]);
            if (hit)        react_ms <= ms_cnt;
        end
    end

`ifdef REACTION_BEST_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                         best_ms <= 14'h3FFF;
        else if (hit && ms_cnt < best_ms)   best_ms <= ms_cnt;
    end
`else
    assign best_ms = 14'h3FFF;
`endif

    always @(posedge clk) begin
        if (!rst_n)
            assert (MIN_DELAY_MS >= 1 && TIMEOUT_MS <= 16383 &&
                    MIN_DELAY_MS + (1 << RAND_BITS) - 1 <= 16383);
    end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl at CLK_PER_MS=4, MIN_DELAY_MS=3, RAND_BITS=2, TIMEOUT_MS=5.
module tb_reaction_game_ctrl;
    localparam logic [2:0] IDLE = 3'b000, WAIT = 3'b001, GO = 3'b011, FAIL = 3'b010, SUCC = 3'b111;
`ifdef REACTION_BEST_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, react;
    logic [2:0]  state;
    logic [13:0] react_ms, best_ms;
    logic        result_valid;
    logic [15:0] m_lfsr;
    int          n_chk = 0, n_fail = 0;
    int          n;
    logic        saw_rv;

    reaction_game_ctrl #(.CLK_PER_MS(4), .MIN_DELAY_MS(3), .RAND_BITS(2), .TIMEOUT_MS(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .react(react),
        .state(state), .react_ms(react_ms), .result_valid(result_valid), .best_ms(best_ms)
    );

    always #5 clk = ~clk;

    // Reference LFSR used only to know which random draw a start press will pick up.
    always @(posedge clk)
        m_lfsr <= !rst_n ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic run_until(input logic [2:0] s, input int max, output int cnt, output logic rv);
        cnt = 0;
        rv  = 1'b0;
        while (state != s && cnt < max) begin
            step(1);
            cnt++;
            rv |= result_valid;
        end
    endtask

    task automatic wait_lfsr(input logic [1:0] want);
        for (int i = 0; i < 64 && m_lfsr[1:0] != want; i++) step(1);
        if (m_lfsr[1:0] != want) check("lfsr_bound", {30'd0, m_lfsr[1:0]}, {30'd0, want});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; react = 1'b0;
        step(3);
        check("rst_state", state, IDLE);
        check("rst_react_ms", react_ms, 0);
        check("rst_rv", result_valid, 0);
        check("rst_best", best_ms, 14'h3FFF);
        rst_n = 1'b1;

        // delay = 3 + 1 = 4 ms -> 16 cycles in WAIT
        wait_lfsr(2'b01);
        start = 1'b1; step(1); start = 1'b0;
        check("wait_entry", state, WAIT);
        run_until(GO, 100, n, saw_rv);
        check("wait_len", n, 16);
        check("go_entry", state, GO);

        // timeout: 5 ms = 20 cycles
        run_until(FAIL, 100, n, saw_rv);
        check("timeout_len", n, 20);
        check("timeout_state", state, FAIL);
        check("timeout_no_rv", saw_rv, 0);
        check("timeout_react_ms", react_ms, 0);

        // early press 5 cycles into WAIT
        start = 1'b1; step(1); start = 1'b0;
        check("early_wait", state, WAIT);
        step(4); react = 1'b1; step(1); react = 1'b0;
        check("early_state", state, FAIL);
        check("early_rv", result_valid, 0);
        check("early_react_ms", react_ms, 0);

        // success at 2 ms
        start = 1'b1; step(1); start = 1'b0;
        run_until(GO, 200, n, saw_rv);
        check("succ1_go", state, GO);
        step(8); react = 1'b1; step(1); react = 1'b0;
        check("succ1_state", state, SUCC);
        check("succ1_ms", react_ms, 2);
        check("succ1_rv", result_valid, 1);
        check("succ1_best", best_ms, BEST_EN ? 14'd2 : 14'h3FFF);
        step(1);
        check("succ1_rv_drop", result_valid, 0);
        check("succ1_hold", state, SUCC);
        check("succ1_ms_hold", react_ms, 2);

        // second success at 3 ms keeps best at 2
        start = 1'b1; step(1); start = 1'b0;
        run_until(GO, 200, n, saw_rv);
        step(12); react = 1'b1; step(1); react = 1'b0;
        check("succ2_ms", react_ms, 3);
        check("succ2_best", best_ms, BEST_EN ? 14'd2 : 14'h3FFF);

        // react rise on the delay-expiry edge
        wait_lfsr(2'b01);
        start = 1'b1; step(1); start = 1'b0;
        step(15); react = 1'b1; step(1); react = 1'b0;
        check("sim_expiry_state", state, FAIL);
        check("sim_expiry_rv", result_valid, 0);
        check("sim_expiry_ms", react_ms, 3);

        // react rise on the timeout edge
        start = 1'b1; step(1); start = 1'b0;
        run_until(GO, 200, n, saw_rv);
        step(19); react = 1'b1; step(1); react = 1'b0;
        check("sim_to_state", state, SUCC);
        check("sim_to_ms", react_ms, 4);
        check("sim_to_rv", result_valid, 1);
        check("sim_to_best", best_ms, BEST_EN ? 14'd2 : 14'h3FFF);

        // start held through FAIL does not retrigger
        start = 1'b1; step(1);
        check("held_wait", state, WAIT);
        react = 1'b1; step(1); react = 1'b0;
        check("held_fail", state, FAIL);
        step(10);
        check("held_start_fail", state, FAIL);
        start = 1'b0; step(1); start = 1'b1; step(1); start = 1'b0;
        check("repress_wait", state, WAIT);

        // react held high into GO never succeeds
        react = 1'b1; step(1);
        check("held_react_fail", state, FAIL);
        start = 1'b1; step(1); start = 1'b0;
        check("held_react_wait", state, WAIT);
        run_until(GO, 200, n, saw_rv);
        check("held_react_go", state, GO);
        run_until(FAIL, 100, n, saw_rv);
        check("held_react_len", n, 20);
        check("held_react_rv", saw_rv, 0);

        // reset mid-GO
        react = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        run_until(GO, 200, n, saw_rv);
        step(3);
        rst_n = 1'b0; step(1);
        check("rst_go_state", state, IDLE);
        check("rst_go_best", best_ms, 14'h3FFF);
        check("rst_go_ms", react_ms, 0);
        rst_n = 1'b1; step(2);
        check("post_rst_idle", state, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
